// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller FSM driving datapath enables, muxes and ALUOp
// Inputs: clk, rst (sync, active-high), Op/Funct (IR fields), ZF (ALU equality flag).
// Outputs: PCWr, NPCOp, IRWr, RFWr, MemWr, RegDst, WDSel, ALUSrcB, EXTOp, ALUOp, State (debug).
module mc_ctrl #(
  parameter int RA_REG = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       ZF,
  output logic       PCWr,
  output logic [1:0] NPCOp,
  output logic       IRWr,
  output logic       RFWr,
  output logic       MemWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrcB,
  output logic       EXTOp,
  output logic [4:0] ALUOp,
  output logic [3:0] State
);
  localparam logic [4:0] ALU_ADD_OP   = 5'd0;
  localparam logic [4:0] ALU_ADDU_OP  = 5'd1;
  localparam logic [4:0] ALU_SUB_OP   = 5'd2;
  localparam logic [4:0] ALU_SUBU_OP  = 5'd3;
  localparam logic [4:0] ALU_AND_OP   = 5'd4;
  localparam logic [4:0] ALU_OR_OP    = 5'd5;
  localparam logic [4:0] ALU_XOR_OP   = 5'd6;
  localparam logic [4:0] ALU_NOR_OP   = 5'd7;
  localparam logic [4:0] ALU_SLT_OP   = 5'd8;
  localparam logic [4:0] ALU_SLTU_OP  = 5'd9;
  localparam logic [4:0] ALU_SLL_OP   = 5'd10;
  localparam logic [4:0] ALU_SRL_OP   = 5'd11;
  localparam logic [4:0] ALU_SLLV_OP  = 5'd12;
  localparam logic [4:0] ALU_SRLV_OP  = 5'd13;
  localparam logic [4:0] ALU_ORI_OP   = 5'd14;
  localparam logic [4:0] ALU_ANDI_OP  = 5'd15;
  localparam logic [4:0] ALU_XORI_OP  = 5'd16;
  localparam logic [4:0] ALU_ADDI_OP  = 5'd17;
  localparam logic [4:0] ALU_ADDIU_OP = 5'd18;
  // Link target select; a zero RA_REG would mean linking into r0, so fall back to rt.
  localparam logic [1:0] DST_RA = (RA_REG != 0) ? 2'b10 : 2'b00;
  typedef enum logic [3:0] {FETCH = 4'd0, DCD, EXE, ALUWB, MA, MR, MWB, MW, BR} state_t;
  state_t r_state;
  logic w_rtype, w_jr, w_j, w_jal, w_lw, w_sw, w_br, w_exe, w_r_ok, w_imm_ok, w_imm_sext;
  logic [4:0] w_r_alu, w_imm_alu, w_exe_alu;
  assign w_rtype    = Op == 6'b000000;
  assign w_jr       = w_rtype && Funct == 6'b001000;
  assign w_j        = Op == 6'b000010;
  assign w_jal      = Op == 6'b000011;
  assign w_lw       = Op == 6'b100011;
  assign w_sw       = Op == 6'b101011;
  assign w_br       = Op[5:1] == 5'b00010;
  assign w_imm_sext = Op[5:1] == 5'b00100;
  assign w_exe      = w_rtype ? w_r_ok : w_imm_ok;
  assign w_exe_alu  = w_rtype ? w_r_alu : w_imm_alu;
  always_comb begin
    w_r_ok = 1'b1;
    case (Funct)
      6'b100000: w_r_alu = ALU_ADD_OP;
      6'b100001: w_r_alu = ALU_ADDU_OP;
      6'b100010: w_r_alu = ALU_SUB_OP;
      6'b100011: w_r_alu = ALU_SUBU_OP;
      6'b100100: w_r_alu = ALU_AND_OP;
      6'b100101: w_r_alu = ALU_OR_OP;
      6'b100110: w_r_alu = ALU_XOR_OP;
      6'b100111: w_r_alu = ALU_NOR_OP;
      6'b101010: w_r_alu = ALU_SLT_OP;
      6'b101011: w_r_alu = ALU_SLTU_OP;
      6'b000000: w_r_alu = ALU_SLL_OP;
      6'b000010: w_r_alu = ALU_SRL_OP;
      6'b000100: w_r_alu = ALU_SLLV_OP;
      6'b000110: w_r_alu = ALU_SRLV_OP;
      default: begin
        w_r_alu = ALU_ADDU_OP;
        w_r_ok  = 1'b0;
      end
    endcase
  end
  always_comb begin
    w_imm_ok = 1'b1;
    case (Op)
      6'b001101: w_imm_alu = ALU_ORI_OP;
      6'b001100: w_imm_alu = ALU_ANDI_OP;
      6'b001110: w_imm_alu = ALU_XORI_OP;
      6'b001000: w_imm_alu = ALU_ADDI_OP;
      6'b001001: w_imm_alu = ALU_ADDIU_OP;
      default: begin
        w_imm_alu = ALU_ADDU_OP;
        w_imm_ok  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else
      case (r_state)
        FETCH:   r_state <= DCD;
        DCD:     r_state <= w_exe ? EXE : (w_lw || w_sw) ? MA : w_br ? BR : FETCH;
        EXE:     r_state <= ALUWB;
        MA:      r_state <= w_sw ? MW : MR;
        MR:      r_state <= MWB;
        default: r_state <= FETCH;
      endcase
  end
  always_comb begin
    PCWr    = 1'b0;
    NPCOp   = 2'b00;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    MemWr   = 1'b0;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    ALUSrcB = 1'b0;
    EXTOp   = 1'b0;
    ALUOp   = rst ? 5'd0 : ALU_ADDU_OP;
    State   = rst ? 4'd0 : r_state;
    if (!rst)
      case (r_state)
        FETCH: begin
          PCWr = 1'b1;
          IRWr = 1'b1;
        end
        DCD: begin
          PCWr   = w_j || w_jal || w_jr;
          NPCOp  = w_jr ? 2'b11 : {w_j || w_jal, 1'b0};
          RFWr   = w_jal;
          RegDst = w_jal ? DST_RA : 2'b00;
          WDSel  = {w_jal, 1'b0};
        end
        EXE, ALUWB: begin
          ALUOp   = w_exe_alu;
          ALUSrcB = !w_rtype;
          EXTOp   = w_imm_sext;
          RFWr    = r_state == ALUWB;
          RegDst  = {1'b0, w_rtype && r_state == ALUWB};
        end
        MA, MR, MW: begin
          ALUSrcB = 1'b1;
          EXTOp   = 1'b1;
          MemWr   = r_state == MW;
        end
        MWB: begin
          RFWr  = 1'b1;
          WDSel = 2'b01;
        end
        BR: begin
          ALUOp = ALU_SUBU_OP;
          EXTOp = 1'b1;
          NPCOp = 2'b01;
          PCWr  = Op[0] ? !ZF : ZF;
        end
        default: ;
      endcase
  end
endmodule
